// File: rtl/data_path_if.sv
// data_path_if: control-unit signals for data_path and the instruction ROM image it fetches from.
interface data_path_if;
   logic        RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc;
   logic [1:0]  ALUOp;
   logic [3:0]  opcode;
   logic [15:0] IMEM [128];
   modport master (output RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUOp, IMEM,
                   input opcode);
   modport slave (input RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUOp, IMEM,
                  output opcode);
endinterface

// File: rtl/data_path.sv
// data_path: 16-bit single-cycle MIPS-style datapath (PC, ROM fetch, 4x16 regfile, ripple ALU, data memory).
module data_path_alu1 (
   input  logic       a, b, cin, bneg, less,
   input  logic [1:0] op,
   output logic       res, cout
);
   logic bb;
   assign bb   = b ^ bneg;
   assign cout = (a & bb) | (cin & (a ^ bb));
   assign res  = op == 2'b00 ? a & bb : op == 2'b01 ? a | bb : op == 2'b10 ? a ^ bb ^ cin : bneg ? less : a ^ bb;
endmodule

module data_path_alu (
   input  logic [15:0] A, B,
   input  logic        BNegate,
   input  logic [1:0]  Op,
   output logic [15:0] y,
   output logic        carry_out, ovf_raw
);
   logic c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, c15, slt;
   data_path_alu1 ALU0  (.a(A[0]),  .b(B[0]),  .cin(BNegate), .bneg(BNegate), .less(slt),  .op(Op), .res(y[0]),  .cout(c1));
   data_path_alu1 ALU1  (.a(A[1]),  .b(B[1]),  .cin(c1),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[1]),  .cout(c2));
   data_path_alu1 ALU2  (.a(A[2]),  .b(B[2]),  .cin(c2),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[2]),  .cout(c3));
   data_path_alu1 ALU3  (.a(A[3]),  .b(B[3]),  .cin(c3),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[3]),  .cout(c4));
   data_path_alu1 ALU4  (.a(A[4]),  .b(B[4]),  .cin(c4),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[4]),  .cout(c5));
   data_path_alu1 ALU5  (.a(A[5]),  .b(B[5]),  .cin(c5),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[5]),  .cout(c6));
   data_path_alu1 ALU6  (.a(A[6]),  .b(B[6]),  .cin(c6),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[6]),  .cout(c7));
   data_path_alu1 ALU7  (.a(A[7]),  .b(B[7]),  .cin(c7),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[7]),  .cout(c8));
   data_path_alu1 ALU8  (.a(A[8]),  .b(B[8]),  .cin(c8),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[8]),  .cout(c9));
   data_path_alu1 ALU9  (.a(A[9]),  .b(B[9]),  .cin(c9),  .bneg(BNegate), .less(1'b0), .op(Op), .res(y[9]),  .cout(c10));
   data_path_alu1 ALU10 (.a(A[10]), .b(B[10]), .cin(c10), .bneg(BNegate), .less(1'b0), .op(Op), .res(y[10]), .cout(c11));
   data_path_alu1 ALU11 (.a(A[11]), .b(B[11]), .cin(c11), .bneg(BNegate), .less(1'b0), .op(Op), .res(y[11]), .cout(c12));
   data_path_alu1 ALU12 (.a(A[12]), .b(B[12]), .cin(c12), .bneg(BNegate), .less(1'b0), .op(Op), .res(y[12]), .cout(c13));
   data_path_alu1 ALU13 (.a(A[13]), .b(B[13]), .cin(c13), .bneg(BNegate), .less(1'b0), .op(Op), .res(y[13]), .cout(c14));
   data_path_alu1 ALU14 (.a(A[14]), .b(B[14]), .cin(c14), .bneg(BNegate), .less(1'b0), .op(Op), .res(y[14]), .cout(c15));
   data_path_alu1 ALU15 (.a(A[15]), .b(B[15]), .cin(c15), .bneg(BNegate), .less(1'b0), .op(Op), .res(y[15]), .cout(carry_out));
   assign ovf_raw = c15 ^ carry_out;
   // Signed less-than: difference sign bit corrected by overflow, fed back into slice 0.
   assign slt = A[15] ^ B[15] ^ BNegate ^ c15 ^ ovf_raw;
endmodule

module data_path_rf (
   input  logic        clk, rst_n, we,
   input  logic [1:0]  ra1, ra2, wa,
   input  logic [15:0] RD,
   output logic [15:0] rd1, rd2
);
   logic [15:0] regs_q [4];
   logic [15:0] regs_d [4];
   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[wa] = RD;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) regs_q <= '{default: '0};
      else regs_q <= regs_d;
   assign rd1 = regs_q[ra1];
   assign rd2 = regs_q[ra2];
endmodule

module data_path (
   input logic        Clock,
   input logic        Reset,
   data_path_if.slave bus
);
   logic [15:0] pc_q, pc_d;
   logic [15:0] pc_initial, pc2, instruction, Zgjerimi, shifter1beq, readData1, readData2, writeData;
   logic [15:0] mux_ALU, ALU_Out, memToMux, beqAddress, pcbeq, pc_next;
   logic [1:0]  mux_regfile;
   logic [3:0]  ALUCtrl;
   logic [2:0]  funct;
   logic        zerof, overflow, carryout, andMuxBranch, ovf_raw;
   logic [15:0] dmem_q [128];
   assign pc_initial  = pc_q;
   assign instruction = bus.IMEM[pc_initial[7:1]];
   assign bus.opcode  = instruction[15:12];
   assign funct       = instruction[2:0];
   assign Zgjerimi    = {{8{instruction[7]}}, instruction[7:0]};
   assign shifter1beq = {Zgjerimi[14:0], 1'b0};
   assign mux_regfile = bus.RegDst ? instruction[7:6] : instruction[9:8];
   data_path_rf RF (.clk(Clock), .rst_n(Reset), .we(bus.RegWrite), .ra1(instruction[11:10]),
                    .ra2(instruction[9:8]), .wa(mux_regfile), .RD(writeData), .rd1(readData1), .rd2(readData2));
   assign mux_ALU = bus.ALUSrc ? Zgjerimi : readData2;
   always_comb
      ALUCtrl = bus.ALUOp == 2'b01 ? 4'b0110 : bus.ALUOp != 2'b10 ? 4'b0010 :
                funct == 3'd1 ? 4'b0110 : funct == 3'd2 ? 4'b0000 : funct == 3'd3 ? 4'b0001 :
                funct == 3'd4 ? 4'b0111 : funct == 3'd5 ? 4'b0011 : 4'b0010;
   data_path_alu ALU (.A(readData1), .B(mux_ALU), .BNegate(ALUCtrl[2]), .Op(ALUCtrl[1:0]),
                      .y(ALU_Out), .carry_out(carryout), .ovf_raw(ovf_raw));
   assign overflow     = ovf_raw & (ALUCtrl == 4'b0010 || ALUCtrl == 4'b0110);
   assign zerof        = ALU_Out == 16'h0;
   assign memToMux     = bus.MemRead ? dmem_q[ALU_Out[7:1]] : 16'h0;
   assign writeData    = bus.MemToReg ? memToMux : ALU_Out;
   assign pc2          = pc_initial + 16'd2;
   assign beqAddress   = pc2 + shifter1beq;
   assign andMuxBranch = bus.Branch & zerof;
   assign pcbeq        = andMuxBranch ? beqAddress : pc2;
   assign pc_next      = pcbeq;
   assign pc_d         = pc_next;
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) pc_q <= '0;
      else pc_q <= pc_d;
   // Data memory keeps its contents through reset; stores are only blocked while reset is held.
   always_ff @(posedge Clock)
      if (Reset && bus.MemWrite) dmem_q[ALU_Out[7:1]] <= readData2;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: drives instruction/control pairs, predicts results with a behavioural model and scoreboards them.
module tb_data_path;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0, errors = 0;
   data_path_if bus ();
   data_path dut (.Clock(clk), .Reset(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {string tag; logic [15:0] v;} exp_t;
   exp_t sbq[$];
   logic [15:0] m_r [4];
   logic [15:0] m_dmem [128];
   logic [15:0] m_pc;

   // {RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUOp}
   localparam logic [8:0] NOP   = 9'b0_0_0_0_0_0_0_00;
   localparam logic [8:0] ADDI  = 9'b0_0_0_0_1_0_1_00;
   localparam logic [8:0] ADDI3 = 9'b0_0_0_0_1_0_1_11;
   localparam logic [8:0] SW    = 9'b0_0_0_1_0_0_1_00;
   localparam logic [8:0] LW    = 9'b0_0_1_0_1_1_1_00;
   localparam logic [8:0] LWSW  = 9'b0_0_1_1_1_1_1_00;
   localparam logic [8:0] RT    = 9'b1_0_0_0_1_0_0_10;
   localparam logic [8:0] BEQ   = 9'b0_1_0_0_0_0_0_01;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.v = v;
      sbq.push_back(e);
   endtask

   task automatic pop(input logic [15:0] got);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty got %h expected an entry", got);
      end else begin
         e = sbq.pop_front();
         check(e.tag, got, e.v);
      end
   endtask

   task automatic run(input string tag, input logic [15:0] ins, input logic [8:0] ctl);
      logic [15:0] a, b, bsel, imm, alu, wd, pcn;
      logic [16:0] s17, d17;
      logic [2:0]  op;
      logic [1:0]  dst;
      logic        zf, ovf, co;
      @(negedge clk);
      bus.IMEM[m_pc[7:1]] = ins;
      {bus.RegDst, bus.Branch, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemToReg, bus.ALUSrc, bus.ALUOp} = ctl;
      imm  = {{8{ins[7]}}, ins[7:0]};
      a    = m_r[ins[11:10]];
      b    = m_r[ins[9:8]];
      bsel = ctl[2] ? imm : b;
      op   = ctl[1:0] == 2'b01 ? 3'd1 : ctl[1:0] != 2'b10 ? 3'd0 : ins[2:0] > 3'd5 ? 3'd0 : ins[2:0];
      s17  = {1'b0, a} + {1'b0, bsel};
      d17  = {1'b0, a} + {1'b0, ~bsel} + 17'd1;
      case (op)
         3'd0: alu = s17[15:0];
         3'd1: alu = d17[15:0];
         3'd2: alu = a & bsel;
         3'd3: alu = a | bsel;
         3'd4: alu = {15'b0, $signed(a) < $signed(bsel)};
         default: alu = a ^ bsel;
      endcase
      co  = (op == 3'd1 || op == 3'd4) ? d17[16] : s17[16];
      ovf = op == 3'd0 ? (a[15] == bsel[15] && s17[15] != a[15]) :
            op == 3'd1 ? (a[15] != bsel[15] && d17[15] != a[15]) : 1'b0;
      zf  = alu == 16'h0;
      wd  = ctl[3] ? (ctl[6] ? m_dmem[alu[7:1]] : 16'h0) : alu;
      pcn = m_pc + 16'd2 + ((ctl[7] && zf) ? {imm[14:0], 1'b0} : 16'd0);
      dst = ctl[8] ? ins[7:6] : ins[9:8];
      push({tag, ".opcode"}, {12'b0, ins[15:12]});
      push({tag, ".pc"}, m_pc);
      push({tag, ".pc2"}, m_pc + 16'd2);
      push({tag, ".alu"}, alu);
      push({tag, ".wd"}, wd);
      push({tag, ".pc_next"}, pcn);
      push({tag, ".zerof"}, {15'b0, zf});
      push({tag, ".overflow"}, {15'b0, ovf});
      push({tag, ".carryout"}, {15'b0, co});
      #1;
      pop({12'b0, bus.opcode});
      pop(dut.pc_initial);
      pop(dut.pc2);
      pop(dut.ALU_Out);
      pop(dut.writeData);
      pop(dut.pc_next);
      pop({15'b0, dut.zerof});
      pop({15'b0, dut.overflow});
      pop({15'b0, dut.carryout});
      @(posedge clk);
      if (ctl[5]) m_dmem[alu[7:1]] = b;
      if (ctl[4]) m_r[dst] = wd;
      m_pc = pcn;
      push({tag, ".post_pc"}, m_pc);
      for (int i = 0; i < 4; i++) push($sformatf("%s.r%0d", tag, i), m_r[i]);
      #1;
      pop(dut.pc_initial);
      for (int i = 0; i < 4; i++) pop(dut.RF.regs_q[i]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout reached before summary");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      {bus.RegDst, bus.Branch, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemToReg, bus.ALUSrc, bus.ALUOp} = NOP;
      for (int i = 0; i < 128; i++) begin
         bus.IMEM[i] = 16'h0;
         m_dmem[i] = 16'h0;
      end
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
      m_pc = 16'h0;
      #1 check("reset.pc_async", dut.pc_initial, 16'h0);
      repeat (2) @(posedge clk);
      #1 check("reset.pc_held", dut.pc_initial, 16'h0);
      for (int i = 0; i < 4; i++) check($sformatf("reset.r%0d", i), dut.RF.regs_q[i], 16'h0);
      rst_n = 1'b1;
      run("nop", 16'h0000, NOP);
      run("addi_r2_5", 16'h4205, ADDI);
      run("sw_r2_4", 16'hB204, SW);
      run("lw_r1_4", 16'h8104, LW);
      check("lw.r1_const", dut.RF.regs_q[1], 16'd5);
      run("add_r3_r1_r1", 16'h05C0, RT);
      check("add.r3_const", dut.RF.regs_q[3], 16'd10);
      run("beq_taken", 16'h1003, BEQ);
      check("beq.pc_const", dut.pc_initial, 16'd18);
      run("beq_not_taken", 16'h1403, BEQ);
      check("bne.pc_const", dut.pc_initial, 16'd20);
      run("sw_r3_6", 16'hB306, SW);
      run("lw_r2_6", 16'h8206, LW);
      check("lw.r2_const", dut.RF.regs_q[2], 16'd10);
      run("addi_r1_m128", 16'h4180, ADDI);
      for (int k = 0; k < 8; k++) run($sformatf("dbl%0d", k), 16'h0540, RT);
      run("addi_r2_1", 16'h4201, ADDI);
      run("sub_ovf", 16'h06C1, RT);
      check("sub.r3_const", dut.RF.regs_q[3], 16'h7FFF);
      run("addi_r1_m1", 16'h41FF, ADDI);
      run("slt", 16'h06C4, RT);
      check("slt.r3_const", dut.RF.regs_q[3], 16'h0001);
      run("and", 16'h06C2, RT);
      run("or", 16'h06C3, RT);
      run("xor", 16'h06C5, RT);
      run("funct6_add", 16'h06C6, RT);
      run("funct7_add", 16'h06C7, RT);
      run("aluop11_add", 16'h4702, ADDI3);
      run("lw_sw_same", 16'h8204, LWSW);
      run("lw_r3_4", 16'h8304, LW);
      check("rw_same.r3_const", dut.RF.regs_q[3], 16'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("midreset.pc_async", dut.pc_initial, 16'h0);
      for (int i = 0; i < 4; i++) check($sformatf("midreset.r%0d", i), dut.RF.regs_q[i], 16'h0);
      @(posedge clk);
      #1 check("midreset.pc_held", dut.pc_initial, 16'h0);
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
      m_pc = 16'h0;
      rst_n = 1'b1;
      run("lw_after_reset", 16'h8106, LW);
      check("dmem_kept.r1_const", dut.RF.regs_q[1], 16'd10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
